// File: rtl/program_sequencer_if.sv
// Fetch-stage bus between program sequencer, program ROM and ICU.
// master = sequencer side, slave = ROM/ICU/control side.
interface program_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
);
  localparam int SP_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] rom_addr;
  logic [ADDR_W+3:0] rom_data;
  logic [3:0]        instruction;
  logic              jmp;
  logic              rtn;
  logic              flag_f;
  logic              resume;
  logic              halted;
  logic [SP_W-1:0]   sp;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output rom_addr,
    output instruction,
    output halted,
    output sp,
    output stack_ovf,
    output stack_unf,
    input  rom_data,
    input  jmp,
    input  rtn,
    input  flag_f,
    input  resume
  );

  modport slave (
    input  rom_addr,
    input  instruction,
    input  halted,
    input  sp,
    input  stack_ovf,
    input  stack_unf,
    output rom_data,
    output jmp,
    output rtn,
    output flag_f,
    output resume
  );
endinterface

// File: rtl/program_sequencer.sv
// Program counter with call/return stack and halt-on-NOPF.
// JMP pushes its own address; RTN pops it back into PC.
module program_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic rst_n,
  program_sequencer_if.master bus
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [SP_W-1:0]   r_sp;
  logic              r_halted;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] r_stack [DEPTH];

  logic [ADDR_W-1:0] w_opnd;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [IDX_W-1:0]  w_top;
  logic [IDX_W-1:0]  w_push;
  logic              w_empty;
  logic              w_full;

  assign w_opnd   = bus.rom_data[ADDR_W+3:4];
  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_top    = IDX_W'(r_sp - SP_W'(1));
  assign w_push   = IDX_W'(r_sp);
  assign w_empty  = (r_sp == '0);
  assign w_full   = (r_sp >= SP_W'(DEPTH));

  assign bus.rom_addr    = r_pc;
  assign bus.instruction = bus.rom_data[3:0];
  assign bus.halted      = r_halted;
  assign bus.sp          = r_sp;
  assign bus.stack_ovf   = r_ovf;
  assign bus.stack_unf   = r_unf;

  // Sequencer FSM: PC, stack and halt all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_pc     <= '0;
      r_sp     <= '0;
      r_halted <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        r_stack[i] <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.rtn) begin
            if (!w_empty) begin
              r_pc <= r_stack[w_top];
              r_sp <= r_sp - SP_W'(1);
            end else begin
              r_pc  <= w_pc_inc;
              r_unf <= 1'b1;
            end
          end else if (bus.jmp) begin
            r_pc <= w_opnd;
            if (!w_full) begin
              r_stack[w_push] <= r_pc;
              r_sp <= r_sp + SP_W'(1);
            end else begin
              r_ovf <= 1'b1;
            end
          end else if (bus.flag_f) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc <= w_pc_inc;
          end
        end
        HALT: begin
          if (bus.resume) begin
            r_pc     <= w_pc_inc;
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: vector table plus
// hand sequences for stack, halt, wrap and async reset.
module tb_program_sequencer;
  localparam int AW  = 8;
  localparam int D   = 4;
  localparam int SPW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  program_sequencer_if #(.ADDR_W(AW), .DEPTH(D)) bus ();

  program_sequencer #(.ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]  pc;
    logic [SPW-1:0] sp;
    logic           h;
    logic           o;
    logic           u;
  } exp_t;

  typedef struct {
    logic           j, r, f, res;
    logic [AW-1:0]  op;
    logic [AW-1:0]  pc;
    logic [SPW-1:0] sp;
    logic           h;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];

  int errs = 0;
  int checks = 0;
  logic [3:0] cur_op;
  logic e_o, e_u;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic j, input logic r,
                      input logic f, input logic res,
                      input logic [AW-1:0] op,
                      input logic [AW-1:0] pc,
                      input logic [SPW-1:0] sp,
                      input logic h);
    exp_t e;
    bus.jmp = j;
    bus.rtn = r;
    bus.flag_f = f;
    bus.resume = res;
    cur_op = 4'($urandom_range(0, 15));
    bus.rom_data = {op, cur_op};
    e.pc = pc; e.sp = sp; e.h = h; e.o = e_o; e.u = e_u;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("pc", 32'(bus.rom_addr), 32'(e.pc));
      chk("sp", 32'(bus.sp), 32'(e.sp));
      chk("halted", 32'(bus.halted), 32'(e.h));
      chk("ovf", 32'(bus.stack_ovf), 32'(e.o));
      chk("unf", 32'(bus.stack_unf), 32'(e.u));
      chk("instr", 32'(bus.instruction), 32'(cur_op));
    end
  endtask

  task automatic none_to(input logic [AW-1:0] pc,
                         input logic [SPW-1:0] sp);
    step(0, 0, 0, 0, 8'h00, pc, sp, 1'b0);
  endtask

  task automatic reset_chk();
    rst_n = 1'b0;
    bus.jmp = 0; bus.rtn = 0; bus.flag_f = 0; bus.resume = 0;
    #1;
    chk("rst_pc", 32'(bus.rom_addr), 0);
    chk("rst_sp", 32'(bus.sp), 0);
    chk("rst_halt", 32'(bus.halted), 0);
    chk("rst_ovf", 32'(bus.stack_ovf), 0);
    chk("rst_unf", 32'(bus.stack_unf), 0);
    e_o = 1'b0;
    e_u = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.rom_data = '0;
    bus.jmp = 0; bus.rtn = 0; bus.flag_f = 0; bus.resume = 0;
    e_o = 0; e_u = 0;

    tbl[0] = '{0,0,0,0, 8'h00, 8'h01, 0, 0};
    tbl[1] = '{0,0,0,0, 8'h00, 8'h02, 0, 0};
    tbl[2] = '{0,0,0,0, 8'h00, 8'h03, 0, 0};
    tbl[3] = '{0,0,0,1, 8'h00, 8'h04, 0, 0};
    tbl[4] = '{0,0,0,0, 8'h00, 8'h05, 0, 0};
    tbl[5] = '{1,0,0,0, 8'h40, 8'h40, 1, 0};
    tbl[6] = '{0,0,0,0, 8'h00, 8'h41, 1, 0};
    tbl[7] = '{0,0,0,0, 8'h00, 8'h42, 1, 0};
    tbl[8] = '{0,1,0,0, 8'h00, 8'h05, 0, 0};
    tbl[9] = '{0,0,0,0, 8'h00, 8'h06, 0, 0};

    reset_chk();
    for (int i = 0; i < 10; i++)
      step(tbl[i].j, tbl[i].r, tbl[i].f, tbl[i].res,
           tbl[i].op, tbl[i].pc, tbl[i].sp, tbl[i].h);

    for (int p = 7; p <= 16; p++)
      none_to(8'(p), 0);
    e_u = 1'b1;
    step(0, 1, 0, 0, 8'h00, 8'h11, 0, 0);
    none_to(8'h12, 0);
    none_to(8'h13, 0);

    reset_chk();
    step(1, 0, 0, 0, 8'h10, 8'h10, 1, 0);
    step(1, 0, 0, 0, 8'h20, 8'h20, 2, 0);
    step(1, 0, 0, 0, 8'h30, 8'h30, 3, 0);
    step(1, 0, 0, 0, 8'h50, 8'h50, 4, 0);
    e_o = 1'b1;
    step(1, 0, 0, 0, 8'h60, 8'h60, 4, 0);
    step(0, 1, 0, 0, 8'h00, 8'h30, 3, 0);
    step(0, 1, 0, 0, 8'h00, 8'h20, 2, 0);
    step(0, 1, 0, 0, 8'h00, 8'h10, 1, 0);
    step(0, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    e_u = 1'b1;
    step(0, 1, 0, 0, 8'h00, 8'h01, 0, 0);

    reset_chk();
    for (int p = 1; p <= 32; p++)
      none_to(8'(p), 0);
    step(0, 0, 1, 0, 8'h00, 8'h20, 0, 1);
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 0, 8'h00, 8'h20, 0, 1);
    step(1, 1, 1, 0, 8'h70, 8'h20, 0, 1);
    step(0, 0, 1, 1, 8'h00, 8'h21, 0, 0);
    none_to(8'h22, 0);
    step(0, 0, 0, 1, 8'h00, 8'h23, 0, 0);
    none_to(8'h24, 0);

    for (int p = 8'h25; p <= 8'hFF; p++)
      none_to(8'(p), 0);
    none_to(8'h00, 0);
    step(1, 0, 0, 0, 8'hFF, 8'hFF, 1, 0);
    step(1, 0, 0, 0, 8'h80, 8'h80, 2, 0);
    step(0, 1, 0, 0, 8'h00, 8'hFF, 1, 0);
    none_to(8'h00, 1);
    step(1, 0, 0, 0, 8'h90, 8'h90, 2, 0);
    step(0, 0, 1, 0, 8'h00, 8'h90, 2, 1);

    #2;
    reset_chk();
    none_to(8'h01, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
